unit_arbiter: RTL and testbench

//   Shares one ALU and one memory port among N_THREADS thread cores.

---
 rtl/unit_arbiter_pkg.sv | 39 +++
 rtl/unit_arbiter_if.sv | 34 +++
 rtl/unit_arbiter_rr_arbiter.sv | 50 +++++
 rtl/unit_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_unit_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/unit_arbiter_pkg.sv
// Shared types and helpers for the thread-to-unit arbiter: selector encoding,
// operand bundle, memory control words and the memory-side FSM states.
package unit_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_MEM  = 2'd2
  } unit_sel_t;

  // For MEM requests: ctrl = MEM_CTRL_*, a = byte address, b = write data.
  typedef struct packed {
    word_t ctrl;
    word_t a;
    word_t b;
  } unit_in_t;

  localparam word_t MEM_CTRL_READ  = 32'd0;
  localparam word_t MEM_CTRL_WRITE = 32'd1;

  typedef enum logic {
    MEM_ARB_IDLE = 1'b0,
    MEM_ARB_BUSY = 1'b1
  } mem_arb_state_t;

  // Circular successor with an explicit compare so non-power-of-2 counts wrap correctly.
  function automatic logic [4:0] rr_next(input logic [4:0] idx, input logic [4:0] n);
    logic [4:0] nxt;
    if (idx == (n - 5'd1)) begin
      nxt = 5'd0;
    end else begin
      nxt = idx + 5'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/unit_arbiter_if.sv
// Thread-array and shared-unit signal bundle; master is the arbiter's view,
// slave is the view of the threads and units around it.
interface unit_arbiter_if
  import unit_arbiter_pkg::*;
#(
  parameter int N_THREADS = 4
);

  unit_sel_t [N_THREADS-1:0] thr_sel;
  unit_in_t  [N_THREADS-1:0] thr_in;
  logic      [N_THREADS-1:0] thr_ready;
  word_t     [N_THREADS-1:0] thr_out;

  unit_in_t alu_in;
  word_t    alu_out;

  logic  mem_req;
  word_t mem_ctrl;
  word_t mem_addr;
  word_t mem_wdata;
  logic  mem_ack;
  word_t mem_rdata;

  modport master (
    input  thr_sel, thr_in, alu_out, mem_ack, mem_rdata,
    output thr_ready, thr_out, alu_in, mem_req, mem_ctrl, mem_addr, mem_wdata
  );

  modport slave (
    output thr_sel, thr_in, alu_out, mem_ack, mem_rdata,
    input  thr_ready, thr_out, alu_in, mem_req, mem_ctrl, mem_addr, mem_wdata
  );

endinterface

// File: rtl/unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// searching circularly.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_onehot_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [IDX_W:0]   cand_s;
  logic [IDX_W-1:0] idx_s;
  logic             any_s;

  // Candidate index is wrapped by subtraction, never by dropping bits.
  always_comb begin
    cand_s = '0;
    idx_s  = '0;
    any_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand_s >= (IDX_W+1)'(N)) begin
        cand_s = cand_s - (IDX_W+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!any_s && req_i[cand_s[IDX_W-1:0]]) begin
        any_s = 1'b1;
        idx_s = cand_s[IDX_W-1:0];
      end else begin
        any_s = any_s;
      end
    end
  end

  always_comb begin
    gnt_onehot_o = '0;
    if (any_s) begin
      gnt_onehot_o[idx_s] = 1'b1;
    end else begin
      gnt_onehot_o = '0;
    end
    gnt_idx_o = idx_s;
    any_o     = any_s;
  end

endmodule

// File: rtl/unit_arbiter.sv
// Shares one combinational ALU and one handshaked memory port among N_THREADS
// thread cores, with an independent round-robin pointer per unit.
module unit_arbiter
  import unit_arbiter_pkg::*;
#(
  parameter int N_THREADS = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  unit_arbiter_if.master bus
);

  localparam int IDX_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

  logic [N_THREADS-1:0] alu_req_s, mem_reqv_s;
  logic [N_THREADS-1:0] alu_gnt_s, mem_gnt_s;
  logic [IDX_W-1:0]     alu_gnt_idx_s, mem_gnt_idx_s;
  logic                 alu_any_s, mem_any_s;

  logic [IDX_W-1:0] alu_ptr_q, alu_ptr_d;
  logic [IDX_W-1:0] mem_ptr_q, mem_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  mem_arb_state_t   state_q, state_d;
  unit_in_t         payload_q, payload_d;
  unit_in_t         mem_pick_s;
  logic             mem_done_s;

  logic [N_THREADS-1:0] thr_ready_s;
  word_t [N_THREADS-1:0] thr_out_s;
  unit_in_t             alu_in_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return IDX_W'(rr_next(5'(idx), 5'(N_THREADS)));
  endfunction

  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      alu_req_s[i]  = (bus.thr_sel[i] == SEL_ALU);
      mem_reqv_s[i] = (bus.thr_sel[i] == SEL_MEM);
    end
  end

  rr_arbiter #(.N(N_THREADS), .IDX_W(IDX_W)) u_alu_rr (
    .req_i        (alu_req_s),
    .ptr_i        (alu_ptr_q),
    .gnt_onehot_o (alu_gnt_s),
    .gnt_idx_o    (alu_gnt_idx_s),
    .any_o        (alu_any_s)
  );

  rr_arbiter #(.N(N_THREADS), .IDX_W(IDX_W)) u_mem_rr (
    .req_i        (mem_reqv_s),
    .ptr_i        (mem_ptr_q),
    .gnt_onehot_o (mem_gnt_s),
    .gnt_idx_o    (mem_gnt_idx_s),
    .any_o        (mem_any_s)
  );

  // State register: pointers, memory FSM and the latched transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_ptr_q <= '0;
      mem_ptr_q <= '0;
      owner_q   <= '0;
      state_q   <= MEM_ARB_IDLE;
      payload_q <= '0;
    end else begin
      alu_ptr_q <= alu_ptr_d;
      mem_ptr_q <= mem_ptr_d;
      owner_q   <= owner_d;
      state_q   <= state_d;
      payload_q <= payload_d;
    end
  end

  // Payload of the memory winner, AND-OR selected by the one-hot grant.
  always_comb begin
    mem_pick_s = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      if (mem_gnt_s[i]) begin
        mem_pick_s = mem_pick_s | bus.thr_in[i];
      end else begin
        mem_pick_s = mem_pick_s;
      end
    end
  end

  // Next state: ALU pointer advances past each grant; memory FSM latches the
  // winner in IDLE and completes to that same owner on ack.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    payload_d  = payload_q;
    mem_ptr_d  = mem_ptr_q;
    mem_done_s = 1'b0;
    if (alu_any_s) begin
      alu_ptr_d = next_idx(alu_gnt_idx_s);
    end else begin
      alu_ptr_d = alu_ptr_q;
    end
    case (state_q)
      MEM_ARB_IDLE: begin
        if (mem_any_s) begin
          owner_d   = mem_gnt_idx_s;
          payload_d = mem_pick_s;
          state_d   = MEM_ARB_BUSY;
        end else begin
          state_d = MEM_ARB_IDLE;
        end
      end
      MEM_ARB_BUSY: begin
        if (bus.mem_ack) begin
          mem_done_s = 1'b1;
          mem_ptr_d  = next_idx(owner_q);
          state_d    = MEM_ARB_IDLE;
        end else begin
          state_d = MEM_ARB_BUSY;
        end
      end
      default: begin
        state_d = MEM_ARB_IDLE;
      end
    endcase
  end

  // Per-thread completion: NONE/undefined selects complete immediately.
  always_comb begin
    thr_ready_s = '0;
    thr_out_s   = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      case (bus.thr_sel[i])
        SEL_ALU: begin
          if (alu_gnt_s[i]) begin
            thr_ready_s[i] = 1'b1;
            thr_out_s[i]   = bus.alu_out;
          end else begin
            thr_ready_s[i] = 1'b0;
          end
        end
        SEL_MEM: begin
          thr_ready_s[i] = 1'b0;
        end
        default: begin
          thr_ready_s[i] = 1'b1;
        end
      endcase
    end
    if (mem_done_s) begin
      thr_ready_s[owner_q] = 1'b1;
      thr_out_s[owner_q]   = bus.mem_rdata;
    end else begin
      thr_ready_s = thr_ready_s;
    end
    if (alu_any_s) begin
      alu_in_s = bus.thr_in[alu_gnt_idx_s];
    end else begin
      alu_in_s = '0;
    end
  end

  // Everything visible outside is held at zero while reset is asserted.
  always_comb begin
    if (rst_i) begin
      bus.thr_ready = '0;
      bus.thr_out   = '0;
      bus.alu_in    = '0;
      bus.mem_req   = 1'b0;
      bus.mem_ctrl  = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
    end else begin
      bus.thr_ready = thr_ready_s;
      bus.thr_out   = thr_out_s;
      bus.alu_in    = alu_in_s;
      bus.mem_req   = (state_q == MEM_ARB_BUSY);
      bus.mem_ctrl  = payload_q.ctrl;
      bus.mem_addr  = payload_q.a;
      bus.mem_wdata = payload_q.b;
    end
  end

endmodule

// File: tb/tb_unit_arbiter.sv
// Directed bench for unit_arbiter (N=4): a per-cycle vector table for the
// NONE/ALU/concurrent cases plus hand sequences for memory latency and reset.
module tb_unit_arbiter;
  import unit_arbiter_pkg::*;

  localparam logic [1:0] S_N = 2'd0;
  localparam logic [1:0] S_A = 2'd1;
  localparam logic [1:0] S_M = 2'd2;
  localparam logic [1:0] S_U = 2'd3;

  typedef struct {
    logic [3:0][1:0]  sel;
    logic             ack;
    logic [3:0]       exp_rdy;
    logic [3:0][31:0] exp_out;
    logic             exp_req;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[12];

  always #5 clk = ~clk;

  unit_arbiter_if #(.N_THREADS(4)) bus ();

  assign bus.alu_out = bus.alu_in.a + bus.alu_in.b;

  unit_arbiter #(.N_THREADS(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] sel, input logic ack, input logic [3:0] rdy,
                              input logic [127:0] out, input logic req);
    vec_t v;
    v.sel = sel; v.ack = ack; v.exp_rdy = rdy; v.exp_out = out; v.exp_req = req;
    return v;
  endfunction

  task automatic set_thr(input int i, input logic [1:0] s, input word_t a, input word_t b);
    bus.thr_sel[i]     = unit_sel_t'(s);
    bus.thr_in[i].ctrl = MEM_CTRL_READ;
    bus.thr_in[i].a    = a;
    bus.thr_in[i].b    = b;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk({S_N,S_N,S_N,S_N}, 1'b0, 4'b1111, 128'h0, 1'b0);
    vecs[1]  = mk({S_N,S_N,S_N,S_N}, 1'b0, 4'b1111, 128'h0, 1'b0);
    vecs[2]  = mk({S_A,S_A,S_A,S_A}, 1'b0, 4'b0001, {32'd0, 32'd0, 32'd0, 32'd10}, 1'b0);
    vecs[3]  = mk({S_A,S_A,S_A,S_A}, 1'b0, 4'b0010, {32'd0, 32'd0, 32'd11, 32'd0}, 1'b0);
    vecs[4]  = mk({S_A,S_A,S_A,S_A}, 1'b0, 4'b0100, {32'd0, 32'd12, 32'd0, 32'd0}, 1'b0);
    vecs[5]  = mk({S_A,S_A,S_A,S_A}, 1'b0, 4'b1000, {32'd13, 32'd0, 32'd0, 32'd0}, 1'b0);
    vecs[6]  = mk({S_A,S_A,S_A,S_A}, 1'b0, 4'b0001, {32'd0, 32'd0, 32'd0, 32'd10}, 1'b0);
    vecs[7]  = mk({S_N,S_A,S_N,S_M}, 1'b0, 4'b1110, {32'd0, 32'd12, 32'd0, 32'd0}, 1'b0);
    vecs[8]  = mk({S_N,S_A,S_N,S_M}, 1'b0, 4'b1110, {32'd0, 32'd12, 32'd0, 32'd0}, 1'b1);
    vecs[9]  = mk({S_N,S_A,S_N,S_M}, 1'b1, 4'b1111, {32'd0, 32'd12, 32'd0, 32'hA5A5_0000}, 1'b1);
    vecs[10] = mk({S_N,S_N,S_N,S_N}, 1'b1, 4'b1111, 128'h0, 1'b0);
    vecs[11] = mk({S_N,S_N,S_U,S_N}, 1'b0, 4'b1111, 128'h0, 1'b0);

    // Reset: outputs forced low even with ALU requests pending.
    rst = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hA5A5_0000;
    for (int i = 0; i < 4; i++) set_thr(i, S_A, 32'(i), 32'd10);
    nxt();
    @(negedge clk);
    chk("rst_ready", 128'(bus.thr_ready), 128'h0);
    chk("rst_out", bus.thr_out, 128'h0);
    chk("rst_alu_in", 128'(bus.alu_in), 128'h0);
    chk("rst_mem_req", 128'(bus.mem_req), 128'h0);
    nxt();
    rst = 1'b0;

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) bus.thr_sel[i] = unit_sel_t'(vecs[r].sel[i]);
      bus.mem_ack = vecs[r].ack;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", r), 128'(bus.thr_ready), 128'(vecs[r].exp_rdy));
      chk($sformatf("vec%0d_out", r), bus.thr_out, vecs[r].exp_out);
      chk($sformatf("vec%0d_mem_req", r), 128'(bus.mem_req), 128'(vecs[r].exp_req));
      nxt();
    end

    // T1 read at 0x100, ack on the third cycle of mem_req.
    for (int i = 0; i < 4; i++) set_thr(i, S_N, 32'd0, 32'd0);
    set_thr(1, S_M, 32'h100, 32'd0);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_grant_ready", 128'(bus.thr_ready), 128'(4'b1101));
    chk("rd_grant_req", 128'(bus.mem_req), 128'h0);
    for (int c = 0; c < 2; c++) begin
      nxt();
      @(negedge clk);
      chk($sformatf("rd_wait%0d_req", c), 128'(bus.mem_req), 128'h1);
      chk($sformatf("rd_wait%0d_addr", c), 128'(bus.mem_addr), 128'h100);
      chk($sformatf("rd_wait%0d_ready", c), 128'(bus.thr_ready), 128'(4'b1101));
    end
    nxt();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("rd_ack_req", 128'(bus.mem_req), 128'h1);
    chk("rd_ack_ctrl", 128'(bus.mem_ctrl), 128'(MEM_CTRL_READ));
    chk("rd_ack_ready", 128'(bus.thr_ready), 128'(4'b1111));
    chk("rd_ack_out", bus.thr_out, {32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0});
    nxt();
    set_thr(1, S_N, 32'd0, 32'd0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("rd_done_req", 128'(bus.mem_req), 128'h0);
    chk("rd_done_ready", 128'(bus.thr_ready), 128'(4'b1111));

    // T2 single-cycle-ack access moves mem_ptr to 3.
    nxt();
    set_thr(2, S_M, 32'h200, 32'd0);
    @(negedge clk);
    chk("t2_grant_ready", 128'(bus.thr_ready), 128'(4'b1011));
    nxt();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'd1;
    @(negedge clk);
    chk("t2_ack_out", bus.thr_out, {32'd0, 32'd1, 32'd0, 32'd0});

    // T3 and T0 together with mem_ptr=3: T3 first, then T0.
    nxt();
    set_thr(2, S_N, 32'd0, 32'd0);
    set_thr(3, S_M, 32'h300, 32'd0);
    set_thr(0, S_M, 32'h400, 32'd0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("pair_grant_ready", 128'(bus.thr_ready), 128'(4'b0110));
    nxt();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h33;
    @(negedge clk);
    chk("pair_first_addr", 128'(bus.mem_addr), 128'h300);
    chk("pair_first_ready", 128'(bus.thr_ready), 128'(4'b1110));
    chk("pair_first_out", bus.thr_out, {32'h33, 32'd0, 32'd0, 32'd0});
    nxt();
    set_thr(3, S_N, 32'd0, 32'd0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("pair_gap_req", 128'(bus.mem_req), 128'h0);
    nxt();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h44;
    @(negedge clk);
    chk("pair_second_addr", 128'(bus.mem_addr), 128'h400);
    chk("pair_second_out", bus.thr_out, {32'd0, 32'd0, 32'd0, 32'h44});

    // mem_ptr=1 now: T1 beats T0; then reset while BUSY.
    nxt();
    set_thr(1, S_M, 32'h500, 32'd0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("ptr1_grant_ready", 128'(bus.thr_ready), 128'(4'b1100));
    nxt();
    @(negedge clk);
    chk("ptr1_addr", 128'(bus.mem_addr), 128'h500);
    nxt();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", 128'(bus.mem_req), 128'h0);
    chk("midrst_ready", 128'(bus.thr_ready), 128'h0);
    nxt();
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h55;
    @(negedge clk);
    chk("late_ack_ready", 128'(bus.thr_ready), 128'(4'b1100));
    chk("late_ack_out", bus.thr_out, 128'h0);
    chk("late_ack_req", 128'(bus.mem_req), 128'h0);
    nxt();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("postrst_addr", 128'(bus.mem_addr), 128'h400);
    chk("postrst_ready", 128'(bus.thr_ready), 128'(4'b1100));
    nxt();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("postrst_ack_out", bus.thr_out, {32'd0, 32'd0, 32'd0, 32'h55});
    nxt();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) set_thr(i, S_A, 32'(i), 32'd10);
    @(negedge clk);
    chk("postrst_alu_ready", 128'(bus.thr_ready), 128'(4'b0001));
    chk("postrst_alu_out", bus.thr_out, {32'd0, 32'd0, 32'd0, 32'd10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
